shot_clock_ctrl: RTL

Control stage directly upstream of the 24 s shot-clock counter/display block. Debounces the operator buttons and runs a RUN/PAUSE/EXPIRED state machine. Divides the system clock down to one-second count-enable pulses and issues preset loads (24 or 14, BCD) into the down-counter chain. Consumes the counter's all-zero flag to stop counting and drive a timed buzzer.

---
 rtl/shot_clock_pkg.sv | 20 ++
 rtl/btn_debounce.sv | 51 +++++
 rtl/shot_clock_ctrl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/shot_clock_pkg.sv
`default_nettype none
// ============================================================================
// Module   : shot_clock_pkg
// Purpose  : State encoding and BCD preset constants for the shot-clock control.
// Revision : 1.0 - initial release
// ============================================================================
package shot_clock_pkg;

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_RUN     = 2'd1;
    localparam logic [1:0] c_ST_PAUSE   = 2'd2;
    localparam logic [1:0] c_ST_EXPIRED = 2'd3;

    localparam logic [3:0] P24_TENS  = 4'd2;
    localparam logic [3:0] P24_UNITS = 4'd4;
    localparam logic [3:0] P14_TENS  = 4'd1;
    localparam logic [3:0] P14_UNITS = 4'd4;

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module   : btn_debounce
// Purpose  : Accepts a new button level after DB_CYCLES identical samples and
//            emits a registered one-cycle pulse on each accepted rising level.
// Revision : 1.0 - initial release
// ============================================================================
module btn_debounce #(
    parameter int DB_CYCLES = 500000
) (
    input  logic CP,
    input  logic CR,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int                 c_CNT_W    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DB_CYCLES - 1);

    logic [c_CNT_W-1:0] r_cnt;
    logic               r_level;
    logic               r_level_d;
    logic               r_rise;

    always_ff @(posedge CP) begin
        if (CR) begin
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_rise    <= 1'b0;
        end else begin
            r_level_d <= r_level;
            r_rise    <= r_level & ~r_level_d;
            // r_cnt counts consecutive samples that disagree with the accepted level
            if (raw == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_LAST) begin
                r_level <= raw;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign level = r_level;
    assign rise  = r_rise;

endmodule
`default_nettype wire

// File: rtl/shot_clock_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : shot_clock_ctrl
// Purpose  : Button debounce, RUN/PAUSE/EXPIRED control, 1 s count enables and
//            24/14 preset loads for the shot-clock counter. Optional macro:
//            SHOT_AUTO_RELOAD_EN (self-issued 24 load after the buzzer ends).
// Revision : 1.0 - initial release
// ============================================================================
module shot_clock_ctrl
    import shot_clock_pkg::*;
#(
    parameter int CLK_HZ      = 50000000,
    parameter int TICK_HZ     = 1,
    parameter int DB_CYCLES   = 500000,
    parameter int BUZZ_CYCLES = 150000000
) (
    input  logic       CP,
    input  logic       CR,
    input  logic       btn_run,
    input  logic       btn_r24,
    input  logic       btn_r14,
    input  logic       zero,
    output logic       cnt_en,
    output logic       load,
    output logic [3:0] load_d1,
    output logic [3:0] load_d0,
    output logic       buzzer,
    output logic [1:0] state
);

    localparam int                 c_DIV      = CLK_HZ / TICK_HZ;
    localparam int                 c_PRE_W    = $clog2(c_DIV);
    localparam logic [c_PRE_W-1:0] c_PRE_LAST = c_PRE_W'(c_DIV - 1);
    localparam int                 c_BUZ_W    = (BUZZ_CYCLES > 1) ? $clog2(BUZZ_CYCLES) : 1;
    localparam logic [c_BUZ_W-1:0] c_BUZ_LAST = c_BUZ_W'(BUZZ_CYCLES - 1);

    logic [2:0] w_raw;
    logic [2:0] w_rise;
    logic [2:0] w_level_unused;
    logic       w_ev_r24;
    logic       w_ev_r14;
    logic       w_ev_run;

    logic [1:0]         r_state;
    logic               r_cnt_en;
    logic               r_load;
    logic [3:0]         r_d1;
    logic [3:0]         r_d0;
    logic               r_buzzer;
    logic [c_PRE_W-1:0] r_pre;
    logic [c_BUZ_W-1:0] r_buz_cnt;

    assign w_raw = {btn_r14, btn_r24, btn_run};

    for (genvar gi = 0; gi < 3; gi++) begin : g_btn
        btn_debounce #(
            .DB_CYCLES (DB_CYCLES)
        ) u_db (
            .CP    (CP),
            .CR    (CR),
            .raw   (w_raw[gi]),
            .level (w_level_unused[gi]),
            .rise  (w_rise[gi])
        );
    end

    // Same-cycle events resolve r24 > r14 > run; losers are dropped.
    assign w_ev_r24 = w_rise[1];
    assign w_ev_r14 = w_rise[2] & ~w_rise[1];
    assign w_ev_run = w_rise[0] & ~w_rise[1] & ~w_rise[2];

    always_ff @(posedge CP) begin
        if (CR) begin
            r_state   <= c_ST_IDLE;
            r_cnt_en  <= 1'b0;
            r_load    <= 1'b0;
            r_d1      <= '0;
            r_d0      <= '0;
            r_buzzer  <= 1'b0;
            r_pre     <= '0;
            r_buz_cnt <= '0;
        end else begin
            r_cnt_en <= 1'b0;
            r_load   <= 1'b0;
            r_d1     <= '0;
            r_d0     <= '0;
            if (w_ev_r24 || w_ev_r14) begin
                r_load    <= 1'b1;
                r_d1      <= w_ev_r24 ? P24_TENS  : P14_TENS;
                r_d0      <= w_ev_r24 ? P24_UNITS : P14_UNITS;
                r_state   <= c_ST_PAUSE;
                r_buzzer  <= 1'b0;
                r_buz_cnt <= '0;
                r_pre     <= '0;
            end else begin
                case (r_state)
                    c_ST_IDLE: begin
                        r_pre <= '0;
                        if (w_ev_run && !zero) r_state <= c_ST_RUN;
                    end
                    c_ST_RUN: begin
                        if (w_ev_run) begin
                            // prescaler is left untouched so the second resumes mid-way
                            r_state <= c_ST_PAUSE;
                        end else if (zero) begin
                            r_state   <= c_ST_EXPIRED;
                            r_buzzer  <= 1'b1;
                            r_buz_cnt <= '0;
                            r_pre     <= '0;
                        end else if (r_pre == c_PRE_LAST) begin
                            r_cnt_en <= 1'b1;
                            r_pre    <= '0;
                        end else begin
                            r_pre <= r_pre + 1'b1;
                        end
                    end
                    c_ST_PAUSE: begin
                        if (w_ev_run && !zero) r_state <= c_ST_RUN;
                    end
                    c_ST_EXPIRED: begin
                        r_pre <= '0;
                        if (r_buzzer) begin
                            if (r_buz_cnt == c_BUZ_LAST) r_buzzer <= 1'b0;
                            else                         r_buz_cnt <= r_buz_cnt + 1'b1;
                        end
`ifdef SHOT_AUTO_RELOAD_EN
                        else begin
                            r_load    <= 1'b1;
                            r_d1      <= P24_TENS;
                            r_d0      <= P24_UNITS;
                            r_state   <= c_ST_PAUSE;
                            r_buz_cnt <= '0;
                        end
`endif
                    end
                    default: r_state <= c_ST_IDLE;
                endcase
            end
        end
    end

    assign cnt_en  = r_cnt_en;
    assign load    = r_load;
    assign load_d1 = r_d1;
    assign load_d0 = r_d0;
    assign buzzer  = r_buzzer;
    assign state   = r_state;

endmodule
`default_nettype wire
